// File: rtl/product_accumulator.sv
// product_accumulator: streaming signed sum of multiplier products with optional 64-bit saturation on output.
module product_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_last,
  input  logic              cfg_sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n, ocnt_q, ocnt_d;
  logic [63:0]      data_q, data_d, clamp;
  logic             ovf_q, ovf_d, hs, ovf;
  assign prod_ready   = state_q == ACCUM;
  assign out_valid    = state_q == HOLD;
  assign out_data     = data_q;
  assign out_count    = ocnt_q;
  assign out_overflow = ovf_q;
  assign hs    = prod_valid && prod_ready;
  assign sum   = acc_q + {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
  assign cnt_n = &cnt_q ? cnt_q : cnt_q + 1'b1;
  // sum fits in signed 64 bits only when bits ACC_W-1..63 are all copies of the sign
  assign ovf   = !(&sum[ACC_W-1:63] || ~|sum[ACC_W-1:63]);
  assign clamp = sum[ACC_W-1] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ocnt_d  = ocnt_q;
    ovf_d   = ovf_q;
    if (state_q == ACCUM && hs) begin
      acc_d   = prod_last ? '0 : sum;
      cnt_d   = prod_last ? '0 : cnt_n;
      state_d = prod_last ? HOLD : ACCUM;
      if (prod_last) begin
        data_d = (cfg_sat && ovf) ? clamp : sum[63:0];
        ocnt_d = cnt_n;
        ovf_d  = ovf;
      end
    end else if (state_q == HOLD && out_ready) begin
      state_d = ACCUM;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ocnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ocnt_q  <= ocnt_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed scoreboard bench for product_accumulator.
module tb_product_accumulator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prod_valid = 1'b0, prod_ready, prod_last = 1'b0, cfg_sat = 1'b0;
  logic [63:0] prod_data = '0;
  logic        out_valid, out_ready = 1'b0, out_overflow;
  logic [63:0] out_data;
  logic [7:0]  out_count;
  int total = 0, bad = 0;
  typedef struct {logic [63:0] data; logic [7:0] cnt; logic ovf;} res_t;
  res_t sb[$];
  localparam logic signed [71:0] MAXV = 72'sh00_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [71:0] MINV = -MAXV - 72'sd1;
  logic signed [71:0] m_acc = '0;
  int m_n = 0;
  logic [63:0] hold_d;
  product_accumulator dut (
    .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .prod_data(prod_data), .prod_last(prod_last), .cfg_sat(cfg_sat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_overflow(out_overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_add(input logic [63:0] d, input bit last, input bit sat);
    logic signed [71:0] s;
    res_t r;
    s = m_acc + {{8{d[63]}}, d};
    m_n++;
    if (last) begin
      r.ovf  = (s > MAXV) || (s < MINV);
      r.data = !sat ? s[63:0] : (s > MAXV) ? 64'h7FFF_FFFF_FFFF_FFFF :
               (s < MINV) ? 64'h8000_0000_0000_0000 : s[63:0];
      r.cnt  = (m_n > 255) ? 8'd255 : 8'(m_n);
      sb.push_back(r);
      m_acc = '0;
      m_n = 0;
    end else m_acc = s;
  endtask
  // called at a negedge; returns at the negedge after the accepting edge
  task automatic push(input logic [63:0] d, input bit last, input bit sat);
    int n = 0;
    prod_valid = 1'b1; prod_data = d; prod_last = last; cfg_sat = sat;
    while (!prod_ready && n < 50) begin @(negedge clk); n++; end
    chk("push_timeout", 64'(n < 50), 64'd1);
    @(negedge clk);
    model_add(d, last, sat);
    prod_valid = 1'b0; prod_last = 1'b0;
  endtask
  task automatic get_result(input string tag);
    int n = 0;
    res_t r;
    out_ready = 1'b1;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_timeout"}, 64'(n < 50), 64'd1);
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    else begin
      r = sb.pop_front();
      chk({tag, "_data"}, out_data, r.data);
      chk({tag, "_count"}, 64'(out_count), 64'(r.cnt));
      chk({tag, "_ovf"}, 64'(out_overflow), 64'(r.ovf));
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(prod_ready), 64'd1);
  endtask
  initial begin
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_ovf", 64'(out_overflow), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(prod_ready), 64'd1);
    // reset mid-HOLD discards the pending result
    push(64'd42, 1'b1, 1'b0);
    chk("hold_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_data", out_data, 64'd0);
    chk("async_count", 64'(out_count), 64'd0);
    chk("async_ovf", 64'(out_overflow), 64'd0);
    sb.delete(); m_acc = '0; m_n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 64'(prod_ready), 64'd1);
    push(-64'sd5, 1'b1, 1'b0);
    chk("neg5_const", out_data, 64'hFFFF_FFFF_FFFF_FFFB);
    get_result("neg5");
    // back-to-back sum with 1-cycle latency
    push(64'd3, 1'b0, 1'b0);
    push(-64'sd7, 1'b0, 1'b0);
    push(64'd100, 1'b1, 1'b0);
    chk("b2b_latency", 64'(out_valid), 64'd1);
    chk("b2b_const", out_data, 64'd96);
    get_result("b2b");
    push(64'd1, 1'b1, 1'b0);
    chk("cleared_const", out_data, 64'd1);
    get_result("cleared");
    // positive overflow, saturated then truncated
    for (int k = 0; k < 4; k++) push(64'h4000_0000_0000_0000, k == 3, 1'b1);
    chk("psat_const", out_data, 64'h7FFF_FFFF_FFFF_FFFF);
    get_result("psat");
    for (int k = 0; k < 4; k++) push(64'h4000_0000_0000_0000, k == 3, 1'b0);
    chk("ptrunc_const", out_data, 64'd0);
    get_result("ptrunc");
    for (int k = 0; k < 4; k++) push(64'hC000_0000_0000_0000, k == 3, 1'b1);
    chk("nsat_const", out_data, 64'h8000_0000_0000_0000);
    get_result("nsat");
    // backpressure: result held while a product waits upstream
    push(64'd10, 1'b1, 1'b0);
    hold_d = out_data;
    prod_valid = 1'b1; prod_data = 64'd7; prod_last = 1'b1; cfg_sat = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ready", 64'(prod_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_stable", out_data, hold_d);
    end
    out_ready = 1'b1;
    if (sb.size() != 0) begin
      chk("bp_data", out_data, sb[0].data);
      void'(sb.pop_front());
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_turn_ready", 64'(prod_ready), 64'd1);
    chk("bp_turn_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    model_add(64'd7, 1'b1, 1'b0);
    prod_valid = 1'b0; prod_last = 1'b0;
    chk("bp_accept", 64'(out_valid), 64'd1);
    get_result("bp_next");
    // count saturation
    for (int k = 1; k <= 300; k++) push(64'd1, k == 300, 1'b0);
    chk("csat_count", 64'(out_count), 64'd255);
    chk("csat_data", out_data, 64'd300);
    get_result("csat");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/product_accumulator.md
# product_accumulator

Streaming signed accumulator that sits directly downstream of the 32×32 signed multiplier. It consumes the multiplier's 64-bit two's-complement products one per cycle through a valid/ready handshake and sums them in a wide internal accumulator. On the product flagged `prod_last` it emits the dot-product result with a product count and an overflow flag, with optional saturation to 64 bits. It decouples the combinational multiplier from downstream consumers that may apply backpressure.

## Interface
- `PROD_W`, 64: product width; signed two's complement.
- `ACC_W`, 72: internal accumulator width. Must be ≥ `PROD_W`+1.
- `CNT_W`, 8: width of the product counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `prod_valid`  in  1  product present.
- `prod_ready`  out  1  accumulator can take a product.
- `prod_data`  in  `PROD_W`  signed product from the multiplier.
- `prod_last`  in  1  marks the final product of the current sum; qualified by handshake.
- `cfg_sat`  in  1  1 = saturate output to signed 64-bit, 0 = truncate to low 64 bits. Sampled on the last-product handshake.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `out_data`  out  64  signed result.
- `out_count`  out  `CNT_W`  number of products in this sum; saturating.
- `out_overflow`  out  1  full-precision sum did not fit in signed 64 bits.

## Operation
- States:
  - ACCUM: `prod_ready`=1, `out_valid`=0.
  - HOLD: `prod_ready`=0, `out_valid`=1.
- Reset state is ACCUM with accumulator=0 and count=0. All outputs are 0 during and after reset except `prod_ready`, which is 1 after reset.
- **ACCUM, handshake (`prod_valid`&`prod_ready`):**
  - `sum` = acc + sign-extend(`prod_data`) to `ACC_W`. Wraps modulo 2^`ACC_W`.
  - `cnt_n` = count+1, saturating at 2^`CNT_W`−1.
  - If `prod_last`=0: acc←`sum`, count←`cnt_n`, stay in ACCUM.
  - If `prod_last`=1: register the result fields, then clear acc and count to 0 and go to HOLD. Result fields:
    - `out_data` = clamp(`sum`) if `cfg_sat`, else `sum`[63:0].
    - `out_count` = `cnt_n`.
    - `out_overflow` = 1 iff `sum` lies outside [−2^63, 2^63−1].
- **ACCUM, no handshake:** state is unchanged.
- **Clamp rule:** positive out-of-range → 0x7FFF_FFFF_FFFF_FFFF; negative out-of-range → 0x8000_0000_0000_0000; in-range values pass unchanged.
- **HOLD:**
  - `out_data`, `out_count` and `out_overflow` are stable while `out_valid`=1 and `out_ready`=0.
  - On `out_ready`=1: return to ACCUM. `out_valid` drops the next cycle; the output data registers retain their value.
  - Products offered during HOLD are not accepted (`prod_ready`=0). The upstream must hold them.
- `out_count` wraps never; it sticks at max. `out_overflow` is independent of `cfg_sat`.
- **Reset mid-operation:** when `rst_n` falls in any state, all of the following clear asynchronously and the block returns to ACCUM:
  - acc, count and state;
  - `out_valid`, `out_data`, `out_count`, `out_overflow`.
  - Partial sums are discarded.

## Timing
- Throughput: one product per cycle in ACCUM, with no bubbles between products.
- Latency: `out_valid` rises on the first edge after the `prod_last` handshake, i.e. 1 cycle.
- Turnaround: the cycle with `out_valid`&`out_ready` high is followed by `prod_ready`=1. The minimum period per sum is therefore N+1 cycles for N products.
- `prod_ready` is a pure function of state (registered), with no combinational path from `out_ready`.
- `out_valid` never drops without a handshake, except on reset.
- `prod_data`, `prod_last` and `cfg_sat` are ignored on cycles without a handshake.

## Test plan
- **Reset:** assert `rst_n`=0 mid-HOLD with `out_valid`=1.
  - Required: `out_valid`, `out_data`, `out_count` and `out_overflow` go to 0 immediately, and `prod_ready`=1 after release.
  - Then a single product −5 with last → `out_data`=0xFFFF_FFFF_FFFF_FFFB, `out_count`=1, `out_overflow`=0.
- **Back-to-back sum:** products 3, −7, 100 (last) on consecutive cycles.
  - Required: `out_valid` on the cycle after the last; `out_data`=96, `out_count`=3.
  - A second sum of 1 starting after the handshake yields 1, proving the accumulator cleared.
- **Overflow:** four products of 0x4000_0000_0000_0000 (2^62), the last one flagged; sum = 2^64.
  - With `cfg_sat`=1 → `out_data`=0x7FFF_FFFF_FFFF_FFFF, `out_overflow`=1.
  - With `cfg_sat`=0 → `out_data`=0, `out_overflow`=1.
- **Negative saturation:** three products of −2^62 plus a fourth of −2^62 flagged last, `cfg_sat`=1.
  - Required: `out_data`=0x8000_0000_0000_0000, `out_overflow`=1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after the result while `prod_valid`=1.
  - Required: `prod_ready`=0 and outputs stable for all 5 cycles.
  - When `out_ready` rises, the held product is accepted the following cycle.
- **Count saturation** (`CNT_W`=8): 300 products of 1, the last flagged.
  - Required: `out_count`=255, `out_data`=300, `out_overflow`=0.
